// File: rtl/jt10_mix_pkg.sv
// ============================================================================
// Module   : jt10_mix_pkg
// Brief    : Shared types and sizing helpers for the jt10_mix stereo mixer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package jt10_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SAT  = 2'd2
    } state_e;

    function automatic int unity_gain(input int gain_w);
        return 1 << (gain_w - 1);
    endfunction

    // Wide enough that NUM_SRC worst-case products never wrap.
    function automatic int acc_width(input int in_w, input int gain_w, input int num_src);
        return in_w + gain_w + 1 + $clog2(num_src) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jt10_mix_sat.sv
// ============================================================================
// Module   : jt10_mix_sat
// Brief    : Removes the gain scaling from an accumulator and clamps to OUT_W.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jt10_mix_sat #(
    parameter int ACC_W  = 29,
    parameter int GAIN_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] sat,
    output logic                    clip
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        // Arithmetic shift floors toward -inf, matching the original core.
        shifted = acc >>> (GAIN_W - 1);
        sat     = shifted[OUT_W-1:0];
        clip    = 1'b0;
        if (shifted > MAX_V) begin
            sat  = MAX_V[OUT_W-1:0];
            clip = 1'b1;
        end else if (shifted < MIN_V) begin
            sat  = MIN_V[OUT_W-1:0];
            clip = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jt10_mix.sv
// ============================================================================
// Module   : jt10_mix
// Brief    : Time-multiplexed stereo mixer with per-source gain/mute and
//            saturation. Optional clip counter enabled by JT10_MIX_CLIP_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jt10_mix
    import jt10_mix_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IN_W    = 16,
    parameter int GAIN_W  = 8,
    parameter int OUT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cen,
    input  logic [NUM_SRC*IN_W-1:0]     src_l,
    input  logic [NUM_SRC*IN_W-1:0]     src_r,
    input  logic                        src_valid,
    input  logic [NUM_SRC*GAIN_W-1:0]   gain_l,
    input  logic [NUM_SRC*GAIN_W-1:0]   gain_r,
    input  logic [NUM_SRC-1:0]          mute,
    output logic signed [OUT_W-1:0]     snd_left,
    output logic signed [OUT_W-1:0]     snd_right,
    output logic                        snd_sample,
    output logic                        clip_l,
    output logic                        clip_r,
    output logic                        overrun,
    output logic                        busy,
    output logic [15:0]                 clip_cnt,
    input  logic                        clip_clr
);

    localparam int ACC_W  = acc_width(IN_W, GAIN_W, NUM_SRC);
    localparam int PROD_W = IN_W + GAIN_W + 1;
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [NUM_SRC*IN_W-1:0]       snap_src_l_q, snap_src_l_d, snap_src_r_q, snap_src_r_d;
    logic [NUM_SRC*GAIN_W-1:0]     snap_gain_l_q, snap_gain_l_d, snap_gain_r_q, snap_gain_r_d;
    logic [NUM_SRC-1:0]            snap_mute_q, snap_mute_d;
    logic signed [OUT_W-1:0]       snd_left_q, snd_left_d, snd_right_q, snd_right_d;
    logic                          clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic                          snd_sample_q, snd_sample_d, overrun_q, overrun_d;

    logic signed [PROD_W-1:0]      prod_l, prod_r;
    logic signed [OUT_W-1:0]       sat_l, sat_r;
    logic                          sat_clip_l, sat_clip_r;

    // One multiplier per side, fed by the snapshot entry selected by idx.
    always_comb begin
        prod_l = $signed(snap_src_l_q[idx_q*IN_W +: IN_W])
               * $signed({1'b0, snap_gain_l_q[idx_q*GAIN_W +: GAIN_W]});
        prod_r = $signed(snap_src_r_q[idx_q*IN_W +: IN_W])
               * $signed({1'b0, snap_gain_r_q[idx_q*GAIN_W +: GAIN_W]});
        if (snap_mute_q[idx_q]) begin
            prod_l = '0;
            prod_r = '0;
        end
    end

    jt10_mix_sat #(.ACC_W(ACC_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) u_sat_l (
        .acc  (acc_l_q),
        .sat  (sat_l),
        .clip (sat_clip_l)
    );

    jt10_mix_sat #(.ACC_W(ACC_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) u_sat_r (
        .acc  (acc_r_q),
        .sat  (sat_r),
        .clip (sat_clip_r)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_l_d       = acc_l_q;
        acc_r_d       = acc_r_q;
        snap_src_l_d  = snap_src_l_q;
        snap_src_r_d  = snap_src_r_q;
        snap_gain_l_d = snap_gain_l_q;
        snap_gain_r_d = snap_gain_r_q;
        snap_mute_d   = snap_mute_q;
        snd_left_d    = snd_left_q;
        snd_right_d   = snd_right_q;
        clip_l_d      = clip_l_q;
        clip_r_d      = clip_r_q;
        snd_sample_d  = 1'b0;
        overrun_d     = cen & src_valid & (state_q != ST_IDLE);
        if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (src_valid) begin
                        snap_src_l_d  = src_l;
                        snap_src_r_d  = src_r;
                        snap_gain_l_d = gain_l;
                        snap_gain_r_d = gain_r;
                        snap_mute_d   = mute;
                        acc_l_d       = '0;
                        acc_r_d       = '0;
                        idx_d         = '0;
                        state_d       = ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_l_d = acc_l_q + {{(ACC_W-PROD_W){prod_l[PROD_W-1]}}, prod_l};
                    acc_r_d = acc_r_q + {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SAT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_SAT: begin
                    snd_left_d   = sat_l;
                    snd_right_d  = sat_r;
                    clip_l_d     = sat_clip_l;
                    clip_r_d     = sat_clip_r;
                    snd_sample_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            snap_src_l_q  <= '0;
            snap_src_r_q  <= '0;
            snap_gain_l_q <= '0;
            snap_gain_r_q <= '0;
            snap_mute_q   <= '0;
            snd_left_q    <= '0;
            snd_right_q   <= '0;
            clip_l_q      <= 1'b0;
            clip_r_q      <= 1'b0;
            snd_sample_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_l_q       <= acc_l_d;
            acc_r_q       <= acc_r_d;
            snap_src_l_q  <= snap_src_l_d;
            snap_src_r_q  <= snap_src_r_d;
            snap_gain_l_q <= snap_gain_l_d;
            snap_gain_r_q <= snap_gain_r_d;
            snap_mute_q   <= snap_mute_d;
            snd_left_q    <= snd_left_d;
            snd_right_q   <= snd_right_d;
            clip_l_q      <= clip_l_d;
            clip_r_q      <= clip_r_d;
            snd_sample_q  <= snd_sample_d;
            overrun_q     <= overrun_d;
        end
    end

    assign snd_left   = snd_left_q;
    assign snd_right  = snd_right_q;
    assign clip_l     = clip_l_q;
    assign clip_r     = clip_r_q;
    assign snd_sample = snd_sample_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef JT10_MIX_CLIP_CNT_EN
    logic [15:0] clip_cnt_q, clip_cnt_d;

    // Clear has priority over a clipping sample landing on the same edge.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (clip_clr) begin
            clip_cnt_d = '0;
        end else if (snd_sample_d && (clip_l_d || clip_r_d) && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_cnt = clip_cnt_q;
`else
    logic unused_clip_clr;
    assign unused_clip_clr = clip_clr;
    assign clip_cnt        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jt10_mix.sv
// ============================================================================
// Module   : tb_jt10_mix
// Brief    : Directed, table-driven self-checking bench for jt10_mix.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jt10_mix;

    typedef struct {
        logic [63:0] sl;
        logic [63:0] sr;
        logic [31:0] gl;
        logic [31:0] gr;
        logic [3:0]  mute;
        logic [15:0] el;
        logic [15:0] er;
        logic        ecl;
        logic        ecr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, cen, src_valid, clip_clr;
    logic [63:0] src_l, src_r;
    logic [31:0] gain_l, gain_r;
    logic [3:0]  mute;
    logic [15:0] snd_left, snd_right, clip_cnt;
    logic        snd_sample, clip_l, clip_r, overrun, busy;

    int checks = 0, errors = 0;
    int cen_period = 1, phase = 0, clk_cnt = 0;
    int samples = 0, overruns = 0, bad_strobe = 0;
    vec_t vecs[9];

    jt10_mix u_dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .src_l(src_l), .src_r(src_r), .src_valid(src_valid),
        .gain_l(gain_l), .gain_r(gain_r), .mute(mute),
        .snd_left(snd_left), .snd_right(snd_right), .snd_sample(snd_sample),
        .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun), .busy(busy),
        .clip_cnt(clip_cnt), .clip_clr(clip_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk16(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] pk8(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        cen   = (phase == 0);
        phase = (phase + 1) % cen_period;
        @(posedge clk);
        #1;
        clk_cnt++;
        if (snd_sample) begin samples++;  if (!cen) bad_strobe++; end
        if (overrun)    begin overruns++; if (!cen) bad_strobe++; end
    endtask

    task automatic load(input vec_t v);
        src_l = v.sl; src_r = v.sr; gain_l = v.gl; gain_r = v.gr; mute = v.mute;
    endtask

    task automatic scramble();
        src_l = ~src_l; src_r = ~src_r; gain_l = ~gain_l; gain_r = ~gain_r; mute = ~mute;
    endtask

    task automatic accept(output int t);
        src_valid = 1'b1;
        do tick(); while (!cen);
        src_valid = 1'b0;
        t = clk_cnt;
    endtask

    task automatic wait_sample(input string name, input int s0, input int t);
        for (int i = 0; i < 100 && samples == s0; i++) tick();
        chk({name, ".latency"}, (samples > s0) ? clk_cnt - t : -1, 5 * cen_period);
    endtask

    task automatic check_out(input string name, input vec_t v);
        chk({name, ".left"},   snd_left,  v.el);
        chk({name, ".right"},  snd_right, v.er);
        chk({name, ".clip_l"}, clip_l,    v.ecl);
        chk({name, ".clip_r"}, clip_r,    v.ecr);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int s0, o0, t;
        s0 = samples; o0 = overruns;
        load(v);
        accept(t);
        scramble();
        wait_sample(name, s0, t);
        check_out(name, v);
        repeat (3 * cen_period + 2) tick();
        check_out({name, ".hold"}, v);
        chk({name, ".nsamples"}, samples - s0, 1);
        chk({name, ".noverrun"}, overruns - o0, 0);
    endtask

    initial begin
        int s0, o0, t;
        logic [31:0] g;
        g = pk8(8'h80, 8'h80, 8'h80, 8'h80);
        // {src_l, src_r, gain_l, gain_r, mute, exp_l, exp_r, clip_l, clip_r}
        vecs[0] = '{pk16(16'h1000, 0, 0, 0), 64'h0, g, g, 4'b0000, 16'h1000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{pk16(16'h7000, 16'h7000, 16'h7000, 16'h7000),
                    pk16(16'h8000, 16'h8000, 16'h8000, 16'h8000), g, g, 4'b0000,
                    16'h7FFF, 16'h8000, 1'b1, 1'b1};
        vecs[2] = '{pk16(0, 0, 16'hE000, 0), 64'h0, pk8(8'h80, 8'h80, 8'h40, 8'h80), g, 4'b0000,
                    16'hF000, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{pk16(0, 0, 16'hE000, 0), 64'h0, pk8(8'h80, 8'h80, 8'h40, 8'h80), g, 4'b0100,
                    16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{pk16(16'h7FFF, 0, 0, 0), pk16(16'h8000, 0, 0, 0), g, g, 4'b0000,
                    16'h7FFF, 16'h8000, 1'b0, 1'b0};
        vecs[5] = '{pk16(16'h4000, 0, 0, 0), pk16(16'h4000, 16'h0001, 0, 0),
                    pk8(8'hFF, 8'h80, 8'h80, 8'h80), pk8(8'hFF, 8'h80, 8'h80, 8'h80), 4'b0000,
                    16'h7F80, 16'h7F81, 1'b0, 1'b0};
        vecs[6] = '{pk16(16'hFFFF, 0, 0, 0), pk16(16'h0001, 0, 0, 0),
                    pk8(8'h40, 8'h80, 8'h80, 8'h80), pk8(8'h40, 8'h80, 8'h80, 8'h80), 4'b0000,
                    16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{pk16(16'h0100, 16'h0200, 16'hFD00, 16'h0400), pk16(0, 0, 0, 16'h7FFF),
                    g, pk8(8'h80, 8'h80, 8'h80, 8'hFF), 4'b0000,
                    16'h0400, 16'h7FFF, 1'b0, 1'b1};
        vecs[8] = '{pk16(16'h7000, 16'h7000, 16'h7000, 16'h7000),
                    pk16(16'h1000, 16'h1000, 16'h1000, 16'h1000), g, g, 4'b1110,
                    16'h7000, 16'h1000, 1'b0, 1'b0};

        rst_n = 1'b0; cen = 1'b0; src_valid = 1'b0; clip_clr = 1'b0;
        src_l = '1; src_r = '1; gain_l = '1; gain_r = '1; mute = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.left", snd_left, 0);
        chk("reset.right", snd_right, 0);
        chk("reset.flags", {snd_sample, clip_l, clip_r, overrun, busy}, 0);
        chk("reset.clip_cnt", clip_cnt, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Second src_valid two cen later is dropped; result is the first set.
        s0 = samples; o0 = overruns;
        load(vecs[0]);
        accept(t);
        scramble();
        tick();
        load(vecs[1]);
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        chk("ovr.busy", busy, 1);
        chk("ovr.pulse", overruns - o0, 1);
        scramble();
        wait_sample("ovr", s0, t);
        check_out("ovr", vecs[0]);
        repeat (8) tick();
        chk("ovr.nsamples", samples - s0, 1);
        chk("ovr.noverrun", overruns - o0, 1);

        // src_valid on the SAT cycle is dropped, not accepted.
        s0 = samples; o0 = overruns;
        load(vecs[2]);
        accept(t);
        repeat (4) tick();
        load(vecs[1]);
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        chk("satdrop.sample", samples - s0, 1);
        check_out("satdrop", vecs[2]);
        repeat (8) tick();
        chk("satdrop.nsamples", samples - s0, 1);
        chk("satdrop.overrun", overruns - o0, 1);
        chk("satdrop.busy", busy, 0);

        // Reset in the middle of accumulation.
        s0 = samples;
        load(vecs[1]);
        accept(t);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst.left", snd_left, 0);
        chk("midrst.right", snd_right, 0);
        chk("midrst.flags", {snd_sample, clip_l, clip_r, overrun, busy}, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("midrst.nsamples", samples - s0, 0);
        chk("midrst.left_idle", snd_left, 0);
        run_vec("postrst", vecs[0]);

        // Sparse clock enable: same results, three times the latency.
        cen_period = 3; phase = 0;
        run_vec("cen3.v7", vecs[7]);
        run_vec("cen3.v1", vecs[1]);
        run_vec("cen3.v5", vecs[5]);
        cen_period = 1; phase = 0;

        clip_clr = 1'b1; tick(); clip_clr = 1'b0;
        chk("clipcnt.cleared", clip_cnt, 0);
        run_vec("cc.a", vecs[1]);
        run_vec("cc.b", vecs[7]);
        run_vec("cc.c", vecs[0]);
        run_vec("cc.d", vecs[1]);
`ifdef JT10_MIX_CLIP_CNT_EN
        chk("clipcnt.three", clip_cnt, 3);
`else
        chk("clipcnt.tied", clip_cnt, 0);
`endif
        clip_clr = 1'b1; tick(); clip_clr = 1'b0;
        chk("clipcnt.clr", clip_cnt, 0);

        chk("strobe_on_cen", bad_strobe, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
